// File: rtl/param_exec_core.sv
// param_exec_core
//   Parametrised single-issue execution core. Accepts one instruction per
//   cycle over a valid/ready handshake. Most operations complete on the
//   accept edge. DIV runs an iterative restoring divider for DATA_W cycles.
//   The register file (16 entries), data memory and return stack are
//   internal and are not cleared by reset.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   instr_valid  instr holds a valid instruction
//   instr_ready  core accepts instr this cycle (high only in FETCH)
//   instr        {opcode[18:13], r1[12:9], r2[8:5], r3[4:1], x[0]}
//   pc           address of next instruction to fetch
//   result       last register-file write value
//   result_valid one-cycle pulse when result is updated
//   busy         high while the divider runs
//   fault        sticky fault flag
//   fault_code   01 stack overflow, 10 stack underflow, 11 illegal opcode
module param_exec_core #(
    parameter int          DATA_W      = 19,
    parameter int          MEM_AW      = 10,
    parameter int          STACK_DEPTH = 16,
    parameter logic [18:0] XOR_KEY     = 19'hABCD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [18:0]       instr,
    output logic [12:0]       pc,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              busy,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] KEY     = DATA_W'(XOR_KEY);
    localparam logic [SP_W-1:0]   SP_FULL = SP_W'(STACK_DEPTH);

    localparam logic [5:0] OP_NOP = 6'b000000, OP_ADD = 6'b000001,
                           OP_SUB = 6'b000010, OP_MUL = 6'b000011,
                           OP_DIV = 6'b000100, OP_INC = 6'b000101,
                           OP_DEC = 6'b000110, OP_LDI = 6'b000111,
                           OP_AND = 6'b001001, OP_OR  = 6'b001010,
                           OP_XOR = 6'b001011, OP_NOT = 6'b001100,
                           OP_JMP = 6'b010001, OP_BEQ = 6'b010010,
                           OP_BNE = 6'b010011, OP_CAL = 6'b010100,
                           OP_RET = 6'b010101, OP_LD  = 6'b011001,
                           OP_ST  = 6'b011010, OP_ENC = 6'b100010,
                           OP_DCR = 6'b100011;

    typedef enum logic [1:0] {S_FETCH, S_DIV, S_FAULT} state_t;

    state_t              state_q, state_d;
    logic [12:0]         pc_q, pc_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic                fault_q, fault_d;
    logic [1:0]          fault_code_q, fault_code_d;
    logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
    logic [DATA_W-1:0]   div_quo_q, div_quo_d;
    logic [DATA_W-1:0]   div_rem_q, div_rem_d;
    logic [DATA_W-1:0]   div_dvs_q, div_dvs_d;
    logic [3:0]          div_rd_q, div_rd_d;

    logic [DATA_W-1:0]   rf    [16];
    logic [DATA_W-1:0]   mem   [2**MEM_AW];
    logic [12:0]         stack [STACK_DEPTH];

    logic                rf_we, mem_we, stk_we;
    logic [3:0]          rf_waddr;
    logic [DATA_W-1:0]   rf_wdata, mem_wdata;
    logic [MEM_AW-1:0]   mem_waddr;
    logic [IDX_W-1:0]    stk_waddr;
    logic [12:0]         stk_wdata;

    logic [5:0]          opcode;
    logic [3:0]          ra, rb, rc;
    logic [DATA_W-1:0]   ra_val, rb_val, rc_val;
    logic [12:0]         pc_inc, br_off;
    logic [MEM_AW-1:0]   ea, enc_addr;
    logic [IDX_W-1:0]    ret_idx;
    logic                wr;
    logic [DATA_W-1:0]   wval;
    logic [DATA_W:0]     rem_shift;
    logic                div_fits;
    logic [DATA_W-1:0]   rem_next, quo_next;
    logic                unused_x;

    assign unused_x = instr[0];

    assign opcode   = instr[18:13];
    assign ra       = instr[12:9];
    assign rb       = instr[8:5];
    assign rc       = instr[4:1];
    assign ra_val   = rf[ra];
    assign rb_val   = rf[rb];
    assign rc_val   = rf[rc];
    assign pc_inc   = pc_q + 13'd1;
    assign br_off   = {{8{instr[4]}}, instr[4:0]};
    assign ea       = MEM_AW'(rb_val + DATA_W'(instr[4:0]));
    assign enc_addr = MEM_AW'(rb_val);
    assign ret_idx  = IDX_W'(sp_q - SP_W'(1));

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and subtract when it fits. A zero divisor always
    // fits, which yields the all-ones quotient without special casing.
    assign rem_shift = {div_rem_q, div_quo_q[DATA_W-1]};
    assign div_fits  = rem_shift >= {1'b0, div_dvs_q};
    assign rem_next  = div_fits ? DATA_W'(rem_shift - {1'b0, div_dvs_q})
                                : rem_shift[DATA_W-1:0];
    assign quo_next  = {div_quo_q[DATA_W-2:0], div_fits};

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        sp_d           = sp_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        fault_d        = fault_q;
        fault_code_d   = fault_code_q;
        div_cnt_d      = div_cnt_q;
        div_quo_d      = div_quo_q;
        div_rem_d      = div_rem_q;
        div_dvs_d      = div_dvs_q;
        div_rd_d       = div_rd_q;
        rf_we          = 1'b0;
        rf_waddr       = ra;
        rf_wdata       = '0;
        mem_we         = 1'b0;
        mem_waddr      = ea;
        mem_wdata      = ra_val;
        stk_we         = 1'b0;
        stk_waddr      = sp_q[IDX_W-1:0];
        stk_wdata      = pc_inc;
        wr             = 1'b0;
        wval           = '0;

        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    case (opcode)
                        OP_NOP: pc_d = pc_inc;
                        OP_ADD: begin wr = 1'b1; wval = rb_val + rc_val; end
                        OP_SUB: begin wr = 1'b1; wval = rb_val - rc_val; end
                        OP_MUL: begin wr = 1'b1; wval = rb_val * rc_val; end
                        OP_INC: begin wr = 1'b1; wval = ra_val + DATA_W'(1); end
                        OP_DEC: begin wr = 1'b1; wval = ra_val - DATA_W'(1); end
                        OP_LDI: begin wr = 1'b1; wval = DATA_W'(instr[8:0]); end
                        OP_AND: begin wr = 1'b1; wval = rb_val & rc_val; end
                        OP_OR:  begin wr = 1'b1; wval = rb_val | rc_val; end
                        OP_XOR: begin wr = 1'b1; wval = rb_val ^ rc_val; end
                        OP_NOT: begin wr = 1'b1; wval = ~rb_val; end
                        OP_LD:  begin wr = 1'b1; wval = mem[ea]; end
                        OP_ENC, OP_DCR: begin
                            wr   = 1'b1;
                            wval = mem[enc_addr] ^ KEY;
                        end
                        OP_DIV: begin
                            div_rem_d = '0;
                            div_quo_d = rb_val;
                            div_dvs_d = rc_val;
                            div_rd_d  = ra;
                            div_cnt_d = CNT_W'(DATA_W - 1);
                            state_d   = S_DIV;
                        end
                        OP_JMP: pc_d = instr[12:0];
                        OP_BEQ: pc_d = (ra_val == rb_val) ? pc_q + br_off : pc_inc;
                        OP_BNE: pc_d = (ra_val != rb_val) ? pc_q + br_off : pc_inc;
                        OP_CAL: begin
                            if (sp_q == SP_FULL) begin
                                fault_d      = 1'b1;
                                fault_code_d = 2'b01;
                                state_d      = S_FAULT;
                            end else begin
                                stk_we = 1'b1;
                                sp_d   = sp_q + SP_W'(1);
                                pc_d   = instr[12:0];
                            end
                        end
                        OP_RET: begin
                            if (sp_q == '0) begin
                                fault_d      = 1'b1;
                                fault_code_d = 2'b10;
                                state_d      = S_FAULT;
                            end else begin
                                sp_d = sp_q - SP_W'(1);
                                pc_d = stack[ret_idx];
                            end
                        end
                        OP_ST: begin
                            mem_we = 1'b1;
                            pc_d   = pc_inc;
                        end
                        default: begin
                            fault_d      = 1'b1;
                            fault_code_d = 2'b11;
                            state_d      = S_FAULT;
                        end
                    endcase

                    if (wr) begin
                        rf_we          = 1'b1;
                        rf_wdata       = wval;
                        result_d       = wval;
                        result_valid_d = 1'b1;
                        pc_d           = pc_inc;
                    end
                end
            end
            S_DIV: begin
                div_rem_d = rem_next;
                div_quo_d = quo_next;
                div_cnt_d = div_cnt_q - CNT_W'(1);
                // The last iteration retires the instruction on the same edge.
                if (div_cnt_q == '0) begin
                    rf_we          = 1'b1;
                    rf_waddr       = div_rd_q;
                    rf_wdata       = quo_next;
                    result_d       = quo_next;
                    result_valid_d = 1'b1;
                    pc_d           = pc_inc;
                    state_d        = S_FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_FETCH;
            pc_q           <= '0;
            sp_q           <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            fault_q        <= 1'b0;
            fault_code_q   <= 2'b00;
            div_cnt_q      <= '0;
            div_quo_q      <= '0;
            div_rem_q      <= '0;
            div_dvs_q      <= '0;
            div_rd_q       <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            sp_q           <= sp_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            fault_q        <= fault_d;
            fault_code_q   <= fault_code_d;
            div_cnt_q      <= div_cnt_d;
            div_quo_q      <= div_quo_d;
            div_rem_q      <= div_rem_d;
            div_dvs_q      <= div_dvs_d;
            div_rd_q       <= div_rd_d;
        end
    end

    // Storage arrays keep their contents across reset; writes are blocked
    // while reset is held so an instruction presented during reset is lost.
    always_ff @(posedge clk) begin
        if (rst && rf_we)  rf[rf_waddr]     <= rf_wdata;
        if (rst && mem_we) mem[mem_waddr]   <= mem_wdata;
        if (rst && stk_we) stack[stk_waddr] <= stk_wdata;
    end

    assign instr_ready  = (state_q == S_FETCH);
    assign busy         = (state_q == S_DIV);
    assign pc           = pc_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign fault        = fault_q;
    assign fault_code   = fault_code_q;

endmodule

// File: doc/param_exec_core.md
Name: param_exec_core

Overview:
Parametrised successor to the team's 19-bit single-issue execution core. It adds configurable data width, data-memory depth, call-stack depth and XOR key, plus a valid/ready instruction handshake and a multi-cycle iterative divider. It also adds stack overflow/underflow and illegal-opcode faults and a registered result strobe. It sits between the instruction feeder and the rest of the datapath, with a 16-entry register file, data memory and return stack held internally.

Parameters:
DATA_W, 19, register/memory word width (≥8)
MEM_AW, 10, data-memory address width (≤13); depth 2^MEM_AW
STACK_DEPTH, 16, return-stack entries (power of two, ≥2)
XOR_KEY, 19'hABCD, ENC/DEC key, truncated/zero-extended to DATA_W

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-low
instr_valid  in  1  instr holds a valid instruction
instr_ready  out  1  core accepts instr this cycle
instr  in  19  {opcode[18:13], r1[12:9], r2[8:5], r3[4:1], x[0]}
pc  out  13  address of next instruction to fetch
result  out  DATA_W  last register-file write value
result_valid  out  1  one-cycle pulse when result is updated
busy  out  1  high while divider runs
fault  out  1  sticky fault flag
fault_code  out  2  01 stack overflow, 10 stack underflow, 11 illegal opcode

Behaviour:
- Reset (rst low, async): pc=0, sp=0, result=0, result_valid=0, fault=0, fault_code=0, busy=0, state=FETCH. Regfile, memory and stack contents are not reset.
- States: FETCH, DIV, FAULT. instr_ready = (state==FETCH). An instruction is accepted at a rising edge where instr_valid && instr_ready.
- Single-cycle ops complete on the accept edge: the register write and pc update land there. result and result_valid=1 are registered on the same edge, so result_valid is visible for exactly the following cycle.
- Default pc update is pc+1, modulo 2^13. Any wrap is silent.
- Arithmetic wraps modulo 2^DATA_W. MUL keeps the low DATA_W bits.
- Opcodes:
  - 000001 ADD r1=r2+r3
  - 000010 SUB r1=r2-r3
  - 000011 MUL r1=r2*r3
  - 000100 DIV r1=r2/r3 (unsigned)
  - 000101 INC r1
  - 000110 DEC r1
  - 000111 LDI r1=zero-ext instr[8:0]
  - 001001 AND, 001010 OR, 001011 XOR (r2 op r3)
  - 001100 NOT r1=~r2
- Control-flow opcodes:
  - 010001 JMP: pc=instr[12:0]
  - 010010 BEQ / 010011 BNE: compare r1,r2; if taken, pc = pc + sign-extended instr[4:0], else pc+1
  - 010100 CALL: stack[sp]=pc+1, sp=sp+1, pc=instr[12:0]
  - 010101 RET: sp=sp-1, pc=stack[sp-1]
- Memory opcodes:
  - 011001 LD: r1=mem[ea]
  - 011010 ST: mem[ea]=r1, no result_valid
  - Effective address ea = (r2 + zero-ext instr[4:0]) low MEM_AW bits
- ENC/DEC opcodes: 100010 ENC and 100011 DEC both compute r1 = mem[r2 low MEM_AW bits] ^ XOR_KEY.
- 000000 NOP: pc+1 only.
- DIV timing:
  - On accept, operands are latched and the core enters DIV with busy=1 and instr_ready=0.
  - A restoring divider runs for exactly DATA_W cycles.
  - On the final edge it writes r1, pulses result_valid, increments pc and returns to FETCH.
  - Accept-to-next-ready latency is DATA_W+1 cycles.
  - Divide by zero gives an all-ones quotient, same latency, no fault.
- Stack faults:
  - CALL with sp==STACK_DEPTH is overflow.
  - RET with sp==0 is underflow.
  - The faulting instruction has no side effects: pc and sp unchanged.
- Faults and FAULT state:
  - Any other opcode value is illegal (code 11).
  - On any fault: fault=1, fault_code set, state goes to FAULT.
  - FAULT holds instr_ready=0 until reset and ignores instr_valid.
- Reset asserted mid-DIV aborts the divide with no register write, then applies the reset values.
- instr_valid low in FETCH: the core holds and nothing changes.
- instr changes while not accepted: ignored.
- Source and destination registers may be the same. All reads sample the pre-edge values.

Test Plan:
- LDI r1=5, LDI r2=7, ADD r3=r1+r2 with instr_valid held high → r3 write; result=12 with result_valid pulsing one cycle per op; pc=3.
- LDI r1=100, LDI r2=7, DIV r3 → instr_ready low for 19 cycles, busy=1, result=14, pc=3. Repeat with r2=0 → result=19'h7FFFF, fault=0.
- CALL 0x40 from pc=2 → pc=0x40. RET → pc=3. Then 17 nested CALLs with STACK_DEPTH=16 → 17th sets fault=1, fault_code=01, pc holds at the 17th CALL's target-from address, instr_ready stays 0.
- RET immediately after reset → fault_code=10, pc=0. Opcode 111111 after reset → fault_code=11. Both stay sticky until rst is pulsed low.
- LDI r1=3, LDI r2=3, BEQ r1,r2 with instr[4:0]=5'b11110 at pc=2 → pc=0. BNE on the same operands → pc=3.
- ST mem[r2+4]=r1 (r1=0x1234, r2=10), then ENC r5 from mem[14] → result=0x1234^0xABCD=0xB9F9. DEC back from stored ciphertext → 0x1234. Also assert rst low mid-DIV → divide aborted, pc=0, no result_valid.
